eriscv_bus_ic: RTL and testbench
================================

// Module: eriscv_bus_ic
// PURPOSE
// - Parametrised data-bus interconnect between the eriscv data port and NUM_SLAVES memory-mapped slaves (data_ram, peripherals).
// - Decodes the address, forwards one registered request to the chosen slave and waits for that slave's ack.
// - Stalls the core until the access completes and flags unmapped or timed-out accesses as bus errors.
// PARAMETERS
// - NUM_SLAVES   4                  number of slave ports (1..8)
// - ADDR_W       32                 address width
// - DATA_W       32                 data width; byte-select width = DATA_W/8
// - SLAVE_BASE   {NUM_SLAVES*ADDR_W} packed base addresses; slave k in [k*ADDR_W +: ADDR_W]
// - SLAVE_MASK   {NUM_SLAVES*ADDR_W} packed masks; slave k hits when (addr & mask_k) == base_k
// - TIMEOUT_CYC  255                WAIT cycles before a timeout error (used only with BUS_TIMEOUT_EN)
// PORTS
// - clk       in   1              clock
// - rst       in   1              synchronous reset, active-high
// - m_ce_i    in   1              core request valid; held stable while m_stall_o=1
// - m_we_i    in   1              1=write, 0=read
// - m_addr_i  in   ADDR_W         byte address
// - m_sel_i   in   DATA_W/8       byte lane select
// - m_data_i  in   DATA_W         write data
// - m_data_o  out  DATA_W         read data; valid in RESP
// - m_stall_o out  1              core must hold its request
// - m_err_o   out  1              bus error; valid in RESP
// - s_ce_o    out  NUM_SLAVES     one-hot slave select
// - s_we_o    out  1              registered write enable, common to all slaves
// - s_addr_o  out  ADDR_W         registered address, common to all slaves
// - s_sel_o   out  DATA_W/8       registered byte select, common to all slaves
// - s_data_o  out  DATA_W         registered write data, common to all slaves
// - s_data_i  in   NUM_SLAVES*DATA_W  packed slave read data
// - s_ack_i   in   NUM_SLAVES     slave completion, one-cycle pulse
// BEHAVIOUR
// - Reset values: state IDLE; s_ce_o=0; s_we_o=0; s_addr_o=0; s_sel_o=0; s_data_o=0; m_data_o=0; m_err_o=0; timeout counter 0.
// - m_stall_o is combinational: 1 in IDLE when m_ce_i=1, 1 in WAIT, 0 in RESP and in IDLE when m_ce_i=0.
// - IDLE, m_ce_i=1, decode hits: the lowest-index hitting slave k wins. Latch we/addr/sel/data, set s_ce_o[k], go to WAIT.
// - IDLE, m_ce_i=1, no hit: go to RESP with m_err_o=1 and m_data_o=0. s_ce_o stays 0. Cost is one stall cycle.
// - WAIT: only s_ack_i[k] is sampled; acks from other slaves are ignored. An ack is not sampled in the IDLE->WAIT transition cycle.
// - WAIT, on ack: clear s_ce_o. A read loads m_data_o from s_data_i[k]; a write loads m_data_o=0. Set m_err_o=0 and go to RESP.
// - RESP: lasts exactly one cycle with stall low, so the core consumes the result. Next cycle returns to IDLE.
// - After RESP, m_data_o and m_err_o hold until the next RESP.
// - Back-to-back requests: minimum 3 cycles each (IDLE, WAIT with same-cycle-registered ack, RESP). No overlap and no outstanding-request queue.
// - Reset mid-WAIT: drops s_ce_o the next edge; the slave's late ack is ignored in IDLE.
// - m_sel_i is forwarded unmodified. Misalignment checking belongs to the core.
// CONFIGURATION
// - BUS_TIMEOUT_EN defined:
//   - The counter clears on WAIT entry and increments every WAIT cycle without an ack.
//   - At count==TIMEOUT_CYC: clear s_ce_o, set m_err_o=1 and m_data_o=0, go to RESP.
//   - An ack arriving in the same cycle as the timeout wins: normal completion.
// - BUS_TIMEOUT_EN undefined: no counter logic; WAIT lasts until ack, with no upper bound.
// STRUCTURE
// - defines.v holds the bus state encodings (`BusIdle 2'b00, `BusWait 2'b01, `BusResp 2'b10) and the default memory-map constants.
// - Sub-module eriscv_addr_decoder: combinational, takes addr, SLAVE_BASE and SLAVE_MASK, outputs one-hot hit[NUM_SLAVES] and any_hit.
//   - Priority to the lowest index.
// - Top level: the FSM, request registers, read-data mux and the timeout counter.
// TESTING
// - Map: slave0 base 0x0000_0000 mask 0xFFFF_F000; slave1 base 0x1000_0000 mask 0xFFFF_F000.
// - Read 0x0000_0010, slave0 acks after 2 WAIT cycles with 0xDEADBEEF:
//   - s_ce_o=4'b0001; stall for 3 cycles; RESP m_data_o=0xDEADBEEF, m_err_o=0.
// - Write 0x1000_0004, sel=4'b0011, data 0x0000_ABCD:
//   - s_ce_o=4'b0010 with s_sel_o=0011 and s_data_o=0x0000ABCD; on ack, RESP m_data_o=0, m_err_o=0.
// - Read 0x2000_0000 (unmapped): s_ce_o never asserts; next cycle RESP with m_err_o=1 and m_data_o=0.
// - Read to slave0 while slave1 pulses ack during WAIT: the ack is ignored, still WAIT; slave0 ack then completes normally.
// - BUS_TIMEOUT_EN, TIMEOUT_CYC=8, slave0 never acks: after 8 WAIT cycles s_ce_o=0 and RESP has m_err_o=1.
//   - A second run with the ack on cycle 8 gives m_err_o=0.
// - rst=1 during WAIT: next edge all outputs are at reset values and state is IDLE; a stray ack afterwards causes no response.

Source files
------------

// File: rtl/eriscv_bus_ic_pkg.sv
// Shared types and default memory map for the eriscv data-bus interconnect.
// Bus state encodings: idle 2'b00, wait 2'b01, resp 2'b10.
package eriscv_bus_ic_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'b00,
        BUS_WAIT = 2'b01,
        BUS_RESP = 2'b10
    } bus_state_e;

    localparam int unsigned DEF_NUM_SLAVES = 4;
    localparam int unsigned DEF_ADDR_W     = 32;

    // Default map: data_ram at 0x0000_0000 (64 KiB), three 4 KiB peripheral windows.
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_BASE = {
        32'h1000_2000, 32'h1000_1000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_MASK = {
        32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000
    };

endpackage

// File: rtl/eriscv_addr_decoder.sv
// Combinational address decoder: one-hot hit vector, lowest index wins on overlap.
module eriscv_addr_decoder #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [NUM_SLAVES*ADDR_W-1:0] base_i,
    input  logic [NUM_SLAVES*ADDR_W-1:0] mask_i,
    output logic [NUM_SLAVES-1:0]        hit_o,
    output logic                         any_hit_o
);

    logic found;

    // NOTE: blocking assignments here are intentional; 'found' must update within
    // the loop so later (higher-index) matches are suppressed.
    always_comb begin
        hit_o = '0;
        found = 1'b0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (!found && ((addr_i & mask_i[k*ADDR_W +: ADDR_W]) == base_i[k*ADDR_W +: ADDR_W])) begin
                hit_o[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_hit_o = found;

endmodule

// File: rtl/eriscv_bus_ic.sv
// eriscv data-bus interconnect: decode, single registered request, wait for ack, one-cycle response.
// Optional timeout on unresponsive slaves is enabled by defining BUS_TIMEOUT_EN.
module eriscv_bus_ic
    import eriscv_bus_ic_pkg::*;
#(
    parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_ce_i,
    input  logic                         m_we_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W/8-1:0]          m_sel_i,
    input  logic [DATA_W-1:0]            m_data_i,
    output logic [DATA_W-1:0]            m_data_o,
    output logic                         m_stall_o,
    output logic                         m_err_o,
    output logic [NUM_SLAVES-1:0]        s_ce_o,
    output logic                         s_we_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic [DATA_W-1:0]            s_data_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
);

    bus_state_e              state_q;
    logic [NUM_SLAVES-1:0]   s_ce_q;
    logic                    s_we_q;
    logic [ADDR_W-1:0]       s_addr_q;
    logic [DATA_W/8-1:0]     s_sel_q;
    logic [DATA_W-1:0]       s_data_q;
    logic [DATA_W-1:0]       m_data_q;
    logic                    m_err_q;

    logic [NUM_SLAVES-1:0]   hit;
    logic                    any_hit;
    logic [DATA_W-1:0]       rd_mux;
    logic                    ack_hit;

    eriscv_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W)
    ) u_dec (
        .addr_i    (m_addr_i),
        .base_i    (SLAVE_BASE),
        .mask_i    (SLAVE_MASK),
        .hit_o     (hit),
        .any_hit_o (any_hit)
    );

    // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (s_ce_q[k]) rd_mux = rd_mux | s_data_i[k*DATA_W +: DATA_W];
        end
    end

    // Only the selected slave's ack counts; s_ce_q is zero outside WAIT.
    assign ack_hit = |(s_ack_i & s_ce_q);

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    assign cnt_d = cnt_q + 1'b1;
`else
    if (TIMEOUT_CYC == 0) begin : g_timeout_unused
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BUS_IDLE;
            s_ce_q   <= '0;
            s_we_q   <= 1'b0;
            s_addr_q <= '0;
            s_sel_q  <= '0;
            s_data_q <= '0;
            m_data_q <= '0;
            m_err_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                BUS_IDLE: begin
                    if (m_ce_i) begin
                        if (any_hit) begin
                            s_ce_q   <= hit;
                            s_we_q   <= m_we_i;
                            s_addr_q <= m_addr_i;
                            s_sel_q  <= m_sel_i;
                            s_data_q <= m_data_i;
`ifdef BUS_TIMEOUT_EN
                            cnt_q    <= '0;
`endif
                            state_q  <= BUS_WAIT;
                        end else begin
                            m_err_q  <= 1'b1;
                            m_data_q <= '0;
                            state_q  <= BUS_RESP;
                        end
                    end
                end
                BUS_WAIT: begin
                    if (ack_hit) begin
                        s_ce_q   <= '0;
                        m_data_q <= s_we_q ? '0 : rd_mux;
                        m_err_q  <= 1'b0;
                        state_q  <= BUS_RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                            s_ce_q   <= '0;
                            m_data_q <= '0;
                            m_err_q  <= 1'b1;
                            state_q  <= BUS_RESP;
                        end
                    end
`endif
                end
                BUS_RESP: state_q <= BUS_IDLE;
                default:  state_q <= BUS_IDLE;
            endcase
        end
    end

    assign m_stall_o = ((state_q == BUS_IDLE) && m_ce_i) || (state_q == BUS_WAIT);
    assign m_data_o  = m_data_q;
    assign m_err_o   = m_err_q;
    assign s_ce_o    = s_ce_q;
    assign s_we_o    = s_we_q;
    assign s_addr_o  = s_addr_q;
    assign s_sel_o   = s_sel_q;
    assign s_data_o  = s_data_q;

endmodule

// File: tb/tb_eriscv_bus_ic.sv
// Directed self-checking bench for eriscv_bus_ic; timeout steps run when BUS_TIMEOUT_EN is defined.
module tb_eriscv_bus_ic;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           m_ce_i;
    logic           m_we_i;
    logic [AW-1:0]  m_addr_i;
    logic [3:0]     m_sel_i;
    logic [DW-1:0]  m_data_i;
    logic [DW-1:0]  m_data_o;
    logic           m_stall_o;
    logic           m_err_o;
    logic [NS-1:0]  s_ce_o;
    logic           s_we_o;
    logic [AW-1:0]  s_addr_o;
    logic [3:0]     s_sel_o;
    logic [DW-1:0]  s_data_o;
    logic [NS*DW-1:0] s_data_i;
    logic [NS-1:0]  s_ack_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eriscv_bus_ic #(
        .NUM_SLAVES  (NS),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SLAVE_BASE  ({32'h5000_0000, 32'h4000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK  ({32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_ce_i    (m_ce_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_sel_i   (m_sel_i),
        .m_data_i  (m_data_i),
        .m_data_o  (m_data_o),
        .m_stall_o (m_stall_o),
        .m_err_o   (m_err_o),
        .s_ce_o    (s_ce_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_sel_o   (s_sel_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven at posedge+1 and sampled at posedge+2.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
        m_ce_i   = 1'b1;
        m_we_i   = we;
        m_addr_i = addr;
        m_sel_i  = sel;
        m_data_i = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ce"},   32'(s_ce_o),   32'h0);
        check({tag, "_s_we"},   32'(s_we_o),   32'h0);
        check({tag, "_s_addr"}, s_addr_o,      32'h0);
        check({tag, "_s_sel"},  32'(s_sel_o),  32'h0);
        check({tag, "_s_data"}, s_data_o,      32'h0);
        check({tag, "_m_data"}, m_data_o,      32'h0);
        check({tag, "_m_err"},  32'(m_err_o),  32'h0);
        check({tag, "_stall"},  32'(m_stall_o), 32'h0);
    endtask

    initial begin
        rst = 1'b1; m_ce_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_sel_i = '0;
        m_data_i = '0; s_data_i = '0; s_ack_i = '0;
        cyc(); cyc(); #1;
        check_reset_outputs("reset");

        // Read slave0 0x10, ack after 2 WAIT cycles.
        rst = 1'b0;
        cyc();
        req(1'b0, 32'h0000_0010, 4'hF, 32'h0); #1;
        check("rd0_idle_stall", 32'(m_stall_o), 32'h1);
        cyc(); #1;
        check("rd0_w1_ce",    32'(s_ce_o),    32'h1);
        check("rd0_w1_addr",  s_addr_o,       32'h0000_0010);
        check("rd0_w1_we",    32'(s_we_o),    32'h0);
        check("rd0_w1_stall", 32'(m_stall_o), 32'h1);
        cyc();
        s_ack_i = 4'b0001; s_data_i[0 +: 32] = 32'hDEAD_BEEF; #1;
        check("rd0_w2_stall", 32'(m_stall_o), 32'h1);
        cyc();
        s_ack_i = '0; m_ce_i = 1'b0; #1;
        check("rd0_resp_stall", 32'(m_stall_o), 32'h0);
        check("rd0_resp_data",  m_data_o,       32'hDEAD_BEEF);
        check("rd0_resp_err",   32'(m_err_o),   32'h0);
        check("rd0_resp_ce",    32'(s_ce_o),    32'h0);
        cyc(); #1;
        check("rd0_hold_data",  m_data_o,       32'hDEAD_BEEF);
        check("rd0_idle_nostall", 32'(m_stall_o), 32'h0);

        // Write slave1 with ack in the first WAIT cycle.
        req(1'b1, 32'h1000_0004, 4'b0011, 32'h0000_ABCD);
        cyc(); #1;
        check("wr1_ce",   32'(s_ce_o),  32'h2);
        check("wr1_sel",  32'(s_sel_o), 32'h3);
        check("wr1_data", s_data_o,     32'h0000_ABCD);
        check("wr1_we",   32'(s_we_o),  32'h1);
        check("wr1_addr", s_addr_o,     32'h1000_0004);
        s_ack_i = 4'b0010; s_data_i[32 +: 32] = 32'h5555_5555;
        cyc();
        s_ack_i = '0; m_ce_i = 1'b0; #1;
        check("wr1_resp_stall", 32'(m_stall_o), 32'h0);
        check("wr1_resp_data",  m_data_o,       32'h0);
        check("wr1_resp_err",   32'(m_err_o),   32'h0);

        // Unmapped read.
        cyc();
        req(1'b0, 32'h2000_0000, 4'hF, 32'h0); #1;
        check("unm_idle_stall", 32'(m_stall_o), 32'h1);
        cyc();
        m_ce_i = 1'b0; #1;
        check("unm_resp_ce",    32'(s_ce_o),    32'h0);
        check("unm_resp_err",   32'(m_err_o),   32'h1);
        check("unm_resp_data",  m_data_o,       32'h0);
        check("unm_resp_stall", 32'(m_stall_o), 32'h0);

        // Read slave0 with a stray ack from slave1 first.
        cyc();
        req(1'b0, 32'h0000_0020, 4'hF, 32'h0);
        cyc();
        s_ack_i = 4'b0010; s_data_i[32 +: 32] = 32'h1111_1111;
        cyc();
        s_ack_i = '0; #1;
        check("ign_still_wait_stall", 32'(m_stall_o), 32'h1);
        check("ign_still_wait_ce",    32'(s_ce_o),    32'h1);
        s_ack_i = 4'b0001; s_data_i[0 +: 32] = 32'hCAFE_F00D;
        cyc();
        s_ack_i = '0; m_ce_i = 1'b0; #1;
        check("ign_resp_data", m_data_o,     32'hCAFE_F00D);
        check("ign_resp_err",  32'(m_err_o), 32'h0);

        // Highest-index slave decode.
        cyc();
        req(1'b0, 32'h5000_0FFC, 4'hF, 32'h0);
        cyc(); #1;
        check("s3_ce", 32'(s_ce_o), 32'h8);
        s_ack_i = 4'b1000; s_data_i[96 +: 32] = 32'h0BAD_F00D;
        cyc();
        s_ack_i = '0; m_ce_i = 1'b0; #1;
        check("s3_resp_data", m_data_o, 32'h0BAD_F00D);

`ifdef BUS_TIMEOUT_EN
        // No ack: timeout fires in the 8th WAIT cycle.
        cyc();
        req(1'b0, 32'h0000_0040, 4'hF, 32'h0);
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        #1;
        check("to_w8_stall", 32'(m_stall_o), 32'h1);
        check("to_w8_ce",    32'(s_ce_o),    32'h1);
        cyc();
        m_ce_i = 1'b0; #1;
        check("to_resp_ce",    32'(s_ce_o),    32'h0);
        check("to_resp_err",   32'(m_err_o),   32'h1);
        check("to_resp_data",  m_data_o,       32'h0);
        check("to_resp_stall", 32'(m_stall_o), 32'h0);

        // Ack in the 8th WAIT cycle beats the timeout.
        cyc();
        req(1'b0, 32'h0000_0044, 4'hF, 32'h0);
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        s_ack_i = 4'b0001; s_data_i[0 +: 32] = 32'h1234_5678;
        cyc();
        s_ack_i = '0; m_ce_i = 1'b0; #1;
        check("to_ack_err",  32'(m_err_o), 32'h0);
        check("to_ack_data", m_data_o,     32'h1234_5678);
`endif

        // Reset mid-WAIT, then a stray ack.
        cyc();
        req(1'b1, 32'h5000_0010, 4'hF, 32'hA5A5_A5A5);
        cyc(); #1;
        check("rstw_ce", 32'(s_ce_o), 32'h8);
        rst = 1'b1; m_ce_i = 1'b0;
        cyc(); #1;
        check_reset_outputs("rstw");
        rst = 1'b0; s_ack_i = 4'b1000;
        cyc();
        s_ack_i = '0; #1;
        check("rstw_stray_stall", 32'(m_stall_o), 32'h0);
        check("rstw_stray_ce",    32'(s_ce_o),    32'h0);
        check("rstw_stray_err",   32'(m_err_o),   32'h0);
        check("rstw_stray_data",  m_data_o,       32'h0);
        cyc(); #1;
        check("rstw_after_err",   32'(m_err_o),   32'h0);
        check("rstw_after_data",  m_data_o,       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
